prog_mem_loader: RTL

//  Boot-time writer for the instruction memory. Consumes a framed byte stream
//  (e.g. from UART RX), packs bytes into 32-bit words and drives the imem write port.

---
 rtl/prog_mem_loader_pkg.sv | 10 +
 rtl/prog_loader_packer.sv | 26 ++
 rtl/prog_mem_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/prog_mem_loader_pkg.sv
// prog_mem_loader_pkg: shared state encoding, frame magic, error codes and default depth.
package prog_mem_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_PAYLOAD, S_CHECK, S_DONE, S_ERROR} state_e;
  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;
  localparam int I_MEM_DEPTH = 2048;
endpackage

// File: rtl/prog_loader_packer.sv
// prog_loader_packer: big-endian byte-to-word shifter; word_valid_o flags the 4th byte of a word.
module prog_loader_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);
  logic [23:0] word_q;
  logic [1:0]  cnt_q;
  assign word_o = {word_q, byte_i};
  assign word_valid_o = byte_valid_i && cnt_q == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      cnt_q <= '0;
    end else if (byte_valid_i) begin
      word_q <= {word_q[15:0], byte_i};
      cnt_q <= cnt_q + 2'd1;
    end
endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: framed byte stream to imem writer; holds the core until a valid image lands.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int MEM_DEPTH = I_MEM_DEPTH,
  parameter int WADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [WADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]            mem_wdata,
  output logic                   core_hold,
  output logic                   load_done,
  output logic                   load_err,
  output logic [1:0]             err_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q;
  logic in_ready_q, mem_we_q, core_hold_q, load_done_q, load_err_q;
  logic [WADDR_WIDTH-1:0] mem_waddr_q, idx_q;
  logic [31:0] mem_wdata_q, word;
  logic [1:0] err_code_q;
  logic [15:0] len_q, n_len;
  logic [TW-1:0] tmo_q;
  logic hs, idle_st, start, tmo_hit, word_valid, last_word, to_fin, to_done;
  assign hs = in_valid && in_ready_q;
  assign idle_st = state_q inside {S_IDLE, S_DONE, S_ERROR};
  assign start = hs && idle_st && in_data == LOADER_MAGIC;
  assign tmo_hit = !idle_st && !hs && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign n_len = {in_data, len_q[7:0]};
  assign last_word = 16'(idx_q) + 16'd1 == len_q;
  assign to_fin = hs && ((state_q == S_LEN1 && n_len == 16'd0) ||
                         (state_q == S_PAYLOAD && word_valid && last_word));
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic csum_ok;
  localparam state_e FIN_STATE = S_CHECK;
  assign csum_ok = 8'(sum_q + in_data) == 8'h00;
  assign to_done = hs && state_q == S_CHECK && csum_ok;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_q <= '0;
    else if (start) sum_q <= '0;
    else if (hs && state_q == S_PAYLOAD) sum_q <= sum_q + in_data;
`else
  localparam state_e FIN_STATE = S_DONE;
  assign to_done = to_fin;
`endif
  prog_loader_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start),
    .byte_valid_i (hs && state_q == S_PAYLOAD),
    .byte_i       (in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      in_ready_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      core_hold_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q <= 1'b0;
      err_code_q <= ERR_NONE;
      len_q <= '0;
      idx_q <= '0;
      tmo_q <= '0;
    end else begin
      in_ready_q <= 1'b1;
      mem_we_q <= 1'b0;
      tmo_q <= (hs || idle_st) ? '0 : tmo_q + 1'b1;
      case (state_q)
        S_LEN0: if (hs) begin
          len_q[7:0] <= in_data;
          state_q <= S_LEN1;
        end
        S_LEN1: if (hs) begin
          len_q <= n_len;
          idx_q <= '0;
          state_q <= n_len > 16'(MEM_DEPTH) ? S_ERROR : S_PAYLOAD;
          if (n_len > 16'(MEM_DEPTH)) begin
            load_err_q <= 1'b1;
            err_code_q <= ERR_LEN;
          end
        end
        S_PAYLOAD: if (word_valid) begin
          mem_we_q <= 1'b1;
          mem_waddr_q <= idx_q;
          mem_wdata_q <= word;
          idx_q <= idx_q + 1'b1;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK: if (hs && !csum_ok) begin
          state_q <= S_ERROR;
          load_err_q <= 1'b1;
          err_code_q <= ERR_CSUM;
        end
`endif
        default: if (start) begin
          state_q <= S_LEN0;
          core_hold_q <= 1'b1;
          load_done_q <= 1'b0;
          load_err_q <= 1'b0;
          err_code_q <= ERR_NONE;
        end
      endcase
      if (to_fin) state_q <= FIN_STATE;
      if (to_done) begin
        state_q <= S_DONE;
        core_hold_q <= 1'b0;
        load_done_q <= 1'b1;
      end
      if (tmo_hit) begin
        state_q <= S_ERROR;
        load_err_q <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
      end
    end
  assign in_ready = in_ready_q;
  assign mem_we = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = core_hold_q;
  assign load_done = load_done_q;
  assign load_err = load_err_q;
  assign err_code = err_code_q;
endmodule
